// File: rtl/gshare_branch_predictor_if.sv
// Fetch/resolve port bundle for the gshare direction predictor.
// The master side drives fetch and resolve information; the slave side is the predictor.
interface gshare_branch_predictor_if #(
  parameter int IDX_W  = 6,
  parameter int GHR_W  = 6,
  parameter int STAT_W = 16
);
  logic              fetch_is_br;
  logic [31:0]       fetch_pc;
  logic              pred_taken;
  logic [IDX_W-1:0]  pred_idx;
  logic [GHR_W-1:0]  pred_ghr;
  logic              res_valid;
  logic [IDX_W-1:0]  res_idx;
  logic [GHR_W-1:0]  res_ghr;
  logic              res_pred_taken;
  logic              res_taken;
  logic              flush;
  logic              ready;
  logic [STAT_W-1:0] stat_branches;
  logic [STAT_W-1:0] stat_mispredicts;

  modport master (
    output fetch_is_br, fetch_pc, res_valid, res_idx, res_ghr, res_pred_taken, res_taken,
    input  pred_taken, pred_idx, pred_ghr, flush, ready, stat_branches, stat_mispredicts
  );

  modport slave (
    input  fetch_is_br, fetch_pc, res_valid, res_idx, res_ghr, res_pred_taken, res_taken,
    output pred_taken, pred_idx, pred_ghr, flush, ready, stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/gshare_branch_predictor.sv
// Gshare/bimodal direction predictor: table of saturating counters indexed by PC (xor GHR),
// trained at resolve, with GHR repair on mispredict and saturating branch statistics.
module gshare_branch_predictor #(
  parameter int ENTRIES = 64,
  parameter int CTR_W   = 2,
  parameter int GHR_W   = 6,
  parameter int USE_GHR = 1,
  parameter int PC_LSB  = 2,
  parameter int STAT_W  = 16
) (
  input logic clk,
  input logic rst,
  gshare_branch_predictor_if.slave bp
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam logic [CTR_W-1:0] WNT     = CTR_W'((1 << (CTR_W - 1)) - 1);
  localparam logic [CTR_W-1:0] CTR_MAX = '1;
  localparam logic [STAT_W-1:0] STAT_MAX = '1;

  localparam logic [0:0] S_INIT = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]        state;
  logic [IDX_W-1:0]  init_ptr;
  logic [GHR_W-1:0]  ghr;
  logic [STAT_W-1:0] stat_br;
  logic [STAT_W-1:0] stat_mp;
  logic [CTR_W-1:0]  ctr_tbl [ENTRIES];

  logic              ready;
  logic              pred_taken;
  logic              flush;
  logic [IDX_W-1:0]  pc_idx;
  logic [IDX_W-1:0]  lookup_idx;
  logic              unused_pc_bits;

  function automatic logic [CTR_W-1:0] ctr_train(input logic [CTR_W-1:0] c, input logic up);
    if (up) return (c == CTR_MAX) ? c : c + 1'b1;
    return (c == '0) ? c : c - 1'b1;
  endfunction

  function automatic logic [STAT_W-1:0] stat_inc(input logic [STAT_W-1:0] s);
    return (s == STAT_MAX) ? s : s + 1'b1;
  endfunction

  assign unused_pc_bits = ^bp.fetch_pc;

  // Lookup: zero-latency read of the pre-update counter
  assign ready      = (state == S_RUN);
  assign pc_idx     = bp.fetch_pc[PC_LSB +: IDX_W];
  assign lookup_idx = (USE_GHR != 0) ? (pc_idx ^ IDX_W'(ghr)) : pc_idx;
  assign pred_taken = ready & ctr_tbl[lookup_idx][CTR_W-1];
  assign flush      = ready & bp.res_valid & (bp.res_pred_taken != bp.res_taken);

  assign bp.pred_taken       = pred_taken;
  assign bp.pred_idx         = lookup_idx;
  assign bp.pred_ghr         = ghr;
  assign bp.flush            = flush;
  assign bp.ready            = ready;
  assign bp.stat_branches    = stat_br;
  assign bp.stat_mispredicts = stat_mp;

  // Counter table: initialised by the INIT sweep rather than by reset
  always_ff @(posedge clk) begin
    if (state == S_INIT) begin
      ctr_tbl[init_ptr] <= WNT;
    end else if (bp.res_valid) begin
      ctr_tbl[bp.res_idx] <= ctr_train(ctr_tbl[bp.res_idx], bp.res_taken);
    end
  end

  // Control: init sweep, GHR repair/speculation, statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_INIT;
      init_ptr <= '0;
      ghr      <= '0;
      stat_br  <= '0;
      stat_mp  <= '0;
    end else if (state == S_INIT) begin
      init_ptr <= init_ptr + 1'b1;
      if (init_ptr == IDX_W'(ENTRIES - 1)) state <= S_RUN;
    end else begin
      // A fetch alongside a flush is on the wrong path, so repair wins
      if (flush) begin
        ghr <= GHR_W'({bp.res_ghr, bp.res_taken});
      end else if (bp.fetch_is_br) begin
        ghr <= GHR_W'({ghr, pred_taken});
      end
      if (bp.res_valid) stat_br <= stat_inc(stat_br);
      if (flush)        stat_mp <= stat_inc(stat_mp);
    end
  end
endmodule

// File: tb/tb_gshare_branch_predictor.sv
// Directed bench: a bimodal instance for training/saturation and a gshare instance
// with 4-bit statistics for GHR repair, aliasing and statistics saturation.
module tb_gshare_branch_predictor;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gshare_branch_predictor_if #(.IDX_W(6), .GHR_W(6), .STAT_W(16)) bi ();
  gshare_branch_predictor_if #(.IDX_W(6), .GHR_W(6), .STAT_W(4))  gs ();

  gshare_branch_predictor #(
    .ENTRIES(64), .CTR_W(2), .GHR_W(6), .USE_GHR(0), .PC_LSB(2), .STAT_W(16)
  ) u_bi (.clk(clk), .rst(rst), .bp(bi.slave));

  gshare_branch_predictor #(
    .ENTRIES(64), .CTR_W(2), .GHR_W(6), .USE_GHR(1), .PC_LSB(2), .STAT_W(4)
  ) u_gs (.clk(clk), .rst(rst), .bp(gs.slave));

  int n_chk  = 0;
  int n_pass = 0;
  int quiet_viol;

  typedef struct {
    logic taken;
    logic pred;
    logic exp_flush;
    logic exp_pred;
  } vec_t;
  vec_t v [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bi.fetch_is_br = 0; bi.fetch_pc = 0; bi.res_valid = 0; bi.res_idx = 0;
    bi.res_ghr = 0; bi.res_pred_taken = 0; bi.res_taken = 0;
    gs.fetch_is_br = 0; gs.fetch_pc = 0; gs.res_valid = 0; gs.res_idx = 0;
    gs.res_ghr = 0; gs.res_pred_taken = 0; gs.res_taken = 0;
  endtask

  // Drives a mispredicting resolve and a fetch branch while waiting for ready.
  task automatic count_ready(output int cnt);
    cnt = 0;
    quiet_viol = 0;
    bi.res_valid = 1; bi.res_idx = 5; bi.res_pred_taken = 0; bi.res_taken = 1;
    bi.fetch_is_br = 1; bi.fetch_pc = 32'h14;
    gs.res_valid = 1; gs.res_idx = 7; gs.res_pred_taken = 0; gs.res_taken = 1;
    gs.fetch_is_br = 1; gs.fetch_pc = 32'h1c;
    while (cnt < 200) begin
      cyc();
      cnt++;
      if (bi.ready) break;
      if (bi.flush || gs.flush || bi.pred_taken || gs.pred_taken || gs.ready) quiet_viol++;
    end
    idle();
  endtask

  initial begin
    int cnt;
    v[0] = '{1, 1, 0, 1};
    v[1] = '{1, 0, 1, 1};
    v[2] = '{1, 1, 0, 1};
    v[3] = '{0, 1, 1, 1};
    v[4] = '{0, 1, 1, 0};
    v[5] = '{0, 0, 0, 0};
    v[6] = '{0, 0, 0, 0};
    v[7] = '{1, 0, 1, 0};
    v[8] = '{1, 0, 1, 1};

    idle();
    rst = 1;
    bi.res_valid = 1; bi.res_pred_taken = 0; bi.res_taken = 1;
    #1;
    chk("rst_ready", bi.ready, 0);
    chk("rst_flush", bi.flush, 0);
    chk("rst_pred", bi.pred_taken, 0);
    idle();
    cyc(); cyc();
    rst = 0;

    count_ready(cnt);
    chk("init_cycles", cnt, 64);
    chk("init_quiet", quiet_viol, 0);
    chk("init_gs_ready", gs.ready, 1);
    chk("init_stat_br", bi.stat_branches, 0);
    chk("init_stat_mp", bi.stat_mispredicts, 0);
    chk("init_ghr", gs.pred_ghr, 0);
    bi.fetch_pc = 32'h14; gs.fetch_pc = 32'h28;
    #1;
    chk("post_init_pred_bi", bi.pred_taken, 0);
    chk("post_init_pred_gs", gs.pred_taken, 0);

    // Reset in RUN, then again 30 cycles into INIT
    cyc();
    rst = 1;
    #1;
    chk("rst_run_ready", bi.ready, 0);
    cyc();
    rst = 0;
    repeat (30) cyc();
    chk("mid_init_ready", bi.ready, 0);
    rst = 1;
    cyc();
    rst = 0;
    count_ready(cnt);
    chk("reinit_cycles", cnt, 64);
    chk("reinit_quiet", quiet_viol, 0);

    // Bimodal training/saturation on index 5 (fetch_pc 0x14)
    bi.fetch_pc = 32'h14;
    #1;
    chk("bi_idx", bi.pred_idx, 5);
    chk("bi_pred_wnt", bi.pred_taken, 0);
    for (int i = 0; i < 9; i++) begin
      bi.res_valid = 1; bi.res_idx = 5;
      bi.res_taken = v[i].taken; bi.res_pred_taken = v[i].pred;
      #1;
      chk($sformatf("vec%0d_flush", i), bi.flush, v[i].exp_flush);
      cyc();
      bi.res_valid = 0;
      #1;
      chk($sformatf("vec%0d_pred", i), bi.pred_taken, v[i].exp_pred);
    end
    chk("bi_stat_br", bi.stat_branches, 9);
    chk("bi_stat_mp", bi.stat_mispredicts, 5);
    chk("bi_ghr", bi.pred_ghr, 1);
    chk("bi_idx_ignores_ghr", bi.pred_idx, 5);

    // Read-during-write: counter 2 trained down to 1
    bi.res_valid = 1; bi.res_idx = 5; bi.res_taken = 0; bi.res_pred_taken = 1;
    #1;
    chk("rdw_old", bi.pred_taken, 1);
    cyc();
    bi.res_valid = 0;
    #1;
    chk("rdw_new", bi.pred_taken, 0);

    // Mispredict with a simultaneous fetch branch: repair wins
    gs.res_valid = 1; gs.res_idx = 40; gs.res_ghr = 6'b101010;
    gs.res_pred_taken = 0; gs.res_taken = 1;
    gs.fetch_is_br = 1; gs.fetch_pc = 32'h0;
    #1;
    chk("mp_flush", gs.flush, 1);
    cyc();
    idle();
    #1;
    chk("mp_ghr_repair", gs.pred_ghr, 6'b010101);
    chk("mp_stat_mp", gs.stat_mispredicts, 1);
    chk("mp_stat_br", gs.stat_branches, 1);

    // Speculative shift of a not-taken prediction
    gs.fetch_is_br = 1; gs.fetch_pc = 32'h0;
    #1;
    chk("spec_idx", gs.pred_idx, 21);
    chk("spec_pred", gs.pred_taken, 0);
    cyc();
    gs.fetch_is_br = 0;
    #1;
    chk("spec_ghr", gs.pred_ghr, 6'b101010);
    cyc();
    chk("hold_ghr", gs.pred_ghr, 6'b101010);

    // Repair to GHR = 000011, then aliasing
    gs.res_valid = 1; gs.res_idx = 40; gs.res_ghr = 6'b000001;
    gs.res_pred_taken = 0; gs.res_taken = 1;
    cyc();
    idle();
    #1;
    chk("alias_ghr", gs.pred_ghr, 6'b000011);
    gs.fetch_pc = 32'h0;
    #1;
    chk("alias_idx_pc0", gs.pred_idx, 3);
    gs.fetch_pc = 32'hc;
    #1;
    chk("alias_idx_pcc", gs.pred_idx, 0);
    repeat (2) begin
      gs.res_valid = 1; gs.res_idx = 3; gs.res_pred_taken = 1; gs.res_taken = 1;
      cyc();
    end
    idle();
    gs.fetch_pc = 32'h0;
    #1;
    chk("alias_pred_pc0", gs.pred_taken, 1);
    gs.fetch_pc = 32'hc;
    #1;
    chk("alias_pred_pcc", gs.pred_taken, 0);
    chk("alias_ghr_held", gs.pred_ghr, 6'b000011);

    // Statistics saturation at 4 bits
    repeat (20) begin
      gs.res_valid = 1; gs.res_idx = 40; gs.res_ghr = 6'b0;
      gs.res_pred_taken = 1; gs.res_taken = 0;
      cyc();
    end
    idle();
    #1;
    chk("sat_stat_br", gs.stat_branches, 15);
    chk("sat_stat_mp", gs.stat_mispredicts, 15);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
